// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  localparam logic [1:0] STOP_1   = 2'b00;
  localparam logic [1:0] STOP_1P5 = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;

  // Stop length in s_tick pulses; modes 10 and 11 both give two stop bits.
  function automatic int unsigned stop_len(input logic [1:0] mode, input int unsigned os);
    case (mode)
      STOP_1:   stop_len = os;
      STOP_1P5: stop_len = (32'd3 * os) / 32'd2;
      default:  stop_len = 32'd2 * os;
    endcase
  endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Parity of the latched word; odd = 1 inverts the even parity.
module uart_parity_gen #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic [DATA_BITS-1:0] word,
  input  logic                 odd,
  output logic                 parity_c
);

  assign parity_c = (^word) ^ odd;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS data, optional parity, 1/1.5/2 stop bits,
// paced by an OVERSAMPLE-per-bit s_tick strobe. Frame config is latched on accept.
module uart_tx_cfg #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic [1:0]           parity_mode,
  input  logic [1:0]           stop_mode,
  output logic                 tx_busy,
  output logic                 tx_done_tick,
  output logic                 tx
);

  import uart_pkg::*;

  localparam int unsigned TW = $clog2(2 * OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] BIT_TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_IDX_LAST  = BW'(DATA_BITS - 1);

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] word_q;
  logic [1:0]           par_q;
  logic [1:0]           stop_q;

  logic [TW-1:0] tick_last_c;
  logic          bit_end_c;
  logic          par_en_c;
  logic          parity_c;

  uart_parity_gen #(.DATA_BITS(DATA_BITS)) u_parity (
    .word     (word_q),
    .odd      (par_q == PARITY_ODD),
    .parity_c (parity_c)
  );

  // A bit period ends on the edge that consumes its last s_tick.
  always_comb begin
    tick_last_c = BIT_TICK_LAST;
    if (state == STOP) begin
      tick_last_c = TW'(stop_len(stop_q, OVERSAMPLE) - 32'd1);
    end
    bit_end_c = s_tick && (tick_cnt == tick_last_c);
    par_en_c  = (par_q == PARITY_EVEN) || (par_q == PARITY_ODD);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_idx      <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      par_q        <= PARITY_NONE;
      stop_q       <= STOP_1;
      tx           <= 1'b1;
      tx_ready     <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      if (state != IDLE && s_tick) begin
        tick_cnt <= bit_end_c ? '0 : tick_cnt + TW'(1);
      end
      // tx follows next-state so each bit appears on the edge its state is entered.
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift_q  <= data_in;
            word_q   <= data_in;
            par_q    <= parity_mode;
            stop_q   <= stop_mode;
            tick_cnt <= '0;
            bit_idx  <= '0;
            state    <= START;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_end_c) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end_c) begin
            shift_q <= shift_q >> 1;
            if (bit_idx == BIT_IDX_LAST) begin
              bit_idx <= '0;
              if (par_en_c) begin
                state <= PARITY;
                tx    <= parity_c;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
              tx      <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end_c) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end_c) begin
            state        <= IDLE;
            tx           <= 1'b1;
            tx_done_tick <= 1'b1;
            tx_ready     <= 1'b1;
            tx_busy      <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
